// File: rtl/q16_pkg.sv
// rtl/q16_pkg.sv - Q16.16 constants, FSM state type and 66-bit round/saturate helper
package q16_pkg;

   localparam int Q_WIDTH = 32;
   localparam int Q_FRAC  = 16;
   localparam int ACC_W   = 2 * Q_WIDTH + 2;

   localparam logic [Q_WIDTH-1:0] Q_ONE = 32'h0001_0000;
   localparam logic [Q_WIDTH-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [Q_WIDTH-1:0] Q_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {sat, value}: round half toward +inf, arithmetic shift, clamp to 32 bits.
   function automatic logic [Q_WIDTH:0] q_round_sat(input logic signed [ACC_W-1:0] sum,
                                                    input int frac);
      logic signed [ACC_W-1:0] t;
      logic signed [ACC_W-1:0] t_max;
      logic signed [ACC_W-1:0] t_min;
      t_max = 66'sd2147483647;
      t_min = -66'sd2147483648;
      t = (sum + (66'sd1 <<< (frac - 1))) >>> frac;
      if (t > t_max) begin
         return {1'b1, Q_MAX};
      end else if (t < t_min) begin
         return {1'b1, Q_MIN};
      end else begin
         return {1'b0, t[Q_WIDTH-1:0]};
      end
   endfunction

endpackage

// File: rtl/q_mac.sv
// rtl/q_mac.sv - registered signed Q16.16 multiply-accumulate with rounded, saturated output
module q_mac
   import q16_pkg::*;
#(
   parameter int FRAC = Q_FRAC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [Q_WIDTH-1:0]  a,
   input  logic signed [Q_WIDTH-1:0]  b,
   output logic        [Q_WIDTH-1:0]  y,
   output logic                       sat
);

   logic signed [ACC_W-1:0]     acc;
   logic signed [2*Q_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]     sum;

   // y/sat reflect acc plus the current product, so a row can be closed in the same cycle.
   assign prod     = a * b;
   assign sum      = acc + $signed({{2{prod[2*Q_WIDTH-1]}}, prod});
   assign {sat, y} = q_round_sat(sum, FRAC);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= sum;
      end
   end

endmodule

// File: rtl/mat3_vec_mul.sv
// rtl/mat3_vec_mul.sv - sequential 3x3 by 3 Q16.16 matrix-vector product, one MAC per cycle
module mat3_vec_mul
   import q16_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] M11,
   input  logic [WIDTH-1:0] M12,
   input  logic [WIDTH-1:0] M13,
   input  logic [WIDTH-1:0] M21,
   input  logic [WIDTH-1:0] M22,
   input  logic [WIDTH-1:0] M23,
   input  logic [WIDTH-1:0] M31,
   input  logic [WIDTH-1:0] M32,
   input  logic [WIDTH-1:0] M33,
   input  logic [WIDTH-1:0] V1,
   input  logic [WIDTH-1:0] V2,
   input  logic [WIDTH-1:0] V3,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic             sat
);

   state_t           state;
   logic [1:0]       r;
   logic [1:0]       c;
   logic [WIDTH-1:0] m_q [0:8];
   logic [WIDTH-1:0] v_q [0:2];
   logic [3:0]       idx;
   logic             accept;
   logic             row_end;
   logic [WIDTH-1:0] mac_y;
   logic             mac_sat;

   assign accept  = (state == IDLE) && start;
   assign row_end = (state == MAC) && (c == 2'd2);
   assign idx     = {2'b00, r} * 4'd3 + {2'b00, c};

   q_mac #(
      .FRAC (FRAC_BITS)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (accept || row_end),
      .en  (state == MAC),
      .a   (m_q[idx]),
      .b   (v_q[c]),
      .y   (mac_y),
      .sat (mac_sat)
   );

   // Operand snapshot; only the accepting edge loads it, so later input changes are harmless.
   always_ff @(posedge clk) begin
      if (accept) begin
         m_q[0] <= M11; m_q[1] <= M12; m_q[2] <= M13;
         m_q[3] <= M21; m_q[4] <= M22; m_q[5] <= M23;
         m_q[6] <= M31; m_q[7] <= M32; m_q[8] <= M33;
         v_q[0] <= V1;  v_q[1] <= V2;  v_q[2] <= V3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sat   <= 1'b0;
         Y1    <= '0;
         Y2    <= '0;
         Y3    <= '0;
         r     <= 2'd0;
         c     <= 2'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sat   <= 1'b0;
                  r     <= 2'd0;
                  c     <= 2'd0;
                  busy  <= 1'b1;
                  state <= MAC;
               end
            end
            MAC: begin
               if (c == 2'd2) begin
                  case (r)
                     2'd0:    Y1 <= mac_y;
                     2'd1:    Y2 <= mac_y;
                     default: Y3 <= mac_y;
                  endcase
                  sat <= sat | mac_sat;
                  c   <= 2'd0;
                  if (r == 2'd2) begin
                     r     <= 2'd0;
                     state <= DONE;
                  end else begin
                     r <= r + 2'd1;
                  end
               end else begin
                  c <= c + 2'd1;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat3_vec_mul.sv
// tb/tb_mat3_vec_mul.sv - scoreboard testbench for mat3_vec_mul with directed vectors
module tb_mat3_vec_mul;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] m [0:8];
   logic [31:0] v [0:2];
   logic        busy;
   logic        done;
   logic [31:0] y1, y2, y3;
   logic        sat;

   typedef struct {
      logic [31:0] y1;
      logic [31:0] y2;
      logic [31:0] y3;
      logic        sat;
      int          k;
   } exp_t;

   exp_t exp_q[$];
   int   edge_cnt = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   mat3_vec_mul dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .M11   (m[0]), .M12 (m[1]), .M13 (m[2]),
      .M21   (m[3]), .M22 (m[4]), .M23 (m[5]),
      .M31   (m[6]), .M32 (m[7]), .M33 (m[8]),
      .V1    (v[0]), .V2  (v[1]), .V3  (v[2]),
      .busy  (busy),
      .done  (done),
      .Y1    (y1),
      .Y2    (y2),
      .Y3    (y3),
      .sat   (sat)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got done at edge %0d, expected none", edge_cnt);
         end else begin
            e = exp_q.pop_front();
            chk("y1", y1, e.y1);
            chk("y2", y2, e.y2);
            chk("y3", y3, e.y3);
            chk("sat", {31'd0, sat}, {31'd0, e.sat});
            chk("latency", edge_cnt - e.k, 32'd10);
         end
      end
   end

   task automatic load(input logic [31:0] mm [0:8], input logic [31:0] vv [0:2]);
      for (int i = 0; i < 9; i++) m[i] = mm[i];
      for (int i = 0; i < 3; i++) v[i] = vv[i];
   endtask

   task automatic scramble();
      for (int i = 0; i < 9; i++) m[i] = $urandom;
      for (int i = 0; i < 3; i++) v[i] = $urandom;
   endtask

   task automatic wait_done(input string name);
      bit got = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s_timeout: got no done, expected done within 30 cycles", name);
      end
   endtask

   task automatic run_op(input string name,
                         input logic [31:0] mm [0:8], input logic [31:0] vv [0:2],
                         input logic [31:0] e1, input logic [31:0] e2,
                         input logic [31:0] e3, input logic es);
      exp_t e;
      @(negedge clk);
      load(mm, vv);
      start = 1'b1;
      e = '{y1: e1, y2: e2, y3: e3, sat: es, k: edge_cnt + 1};
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      scramble();
      wait_done(name);
   endtask

   logic [31:0] m_id [0:8] = '{32'h10000, 0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000};
   logic [31:0] m_t2 [0:8] = '{32'h20000, 0, 0, 0, 32'h8000, 0, 32'h10000, 32'h10000, 32'h10000};
   logic [31:0] m_rd [0:8] = '{32'h1, 0, 0, 0, 0, 0, 0, 0, 0};
   logic [31:0] m_st [0:8] = '{32'h640000, 32'h640000, 32'h640000, 0, 0, 0, 0, 0, 0};
   logic [31:0] m_on [0:8] = '{default: 32'h10000};
   logic [31:0] v_t1 [0:2] = '{32'h10000, 32'hFFFE0000, 32'h8000};
   logic [31:0] v_123[0:2] = '{32'h10000, 32'h20000, 32'h30000};
   logic [31:0] v_rp [0:2] = '{32'h8000, 0, 0};
   logic [31:0] v_rn [0:2] = '{32'hFFFF8000, 0, 0};
   logic [31:0] v_sp [0:2] = '{default: 32'h75300000};
   logic [31:0] v_sn [0:2] = '{default: 32'h8AD00000};
   logic [31:0] v_345[0:2] = '{32'h30000, 32'h40000, 32'h50000};

   initial begin
      int k;
      rst   = 1'b1;
      start = 1'b0;
      scramble();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_y1", y1, 32'd0);
      chk("rst_sat", {31'd0, sat}, 32'd0);
      rst = 1'b0;

      run_op("identity", m_id, v_t1, 32'h10000, 32'hFFFE0000, 32'h8000, 1'b0);
      run_op("mixed", m_t2, v_123, 32'h20000, 32'h10000, 32'h60000, 1'b0);
      run_op("round_pos", m_rd, v_rp, 32'h1, 32'h0, 32'h0, 1'b0);
      run_op("round_neg", m_rd, v_rn, 32'h0, 32'h0, 32'h0, 1'b0);
      run_op("sat_pos", m_st, v_sp, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1);
      run_op("sat_neg", m_st, v_sn, 32'h80000000, 32'h0, 32'h0, 1'b1);
      run_op("sat_clear", m_t2, v_123, 32'h20000, 32'h10000, 32'h60000, 1'b0);

      // Start pulse while in MAC carries different operands and must be ignored.
      @(negedge clk);
      load(m_id, v_345);
      start = 1'b1;
      exp_q.push_back('{y1: 32'h30000, y2: 32'h40000, y3: 32'h50000, sat: 1'b0, k: edge_cnt + 1});
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      load(m_st, v_sp);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start");
      repeat (3) @(negedge clk);

      // Abort in the middle of MAC: rst sampled on edge k+5.
      load(m_st, v_sp);
      start = 1'b1;
      k = edge_cnt + 1;
      @(negedge clk);
      start = 1'b0;
      while (edge_cnt < k + 4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_y1", y1, 32'd0);
      chk("abort_y3", y3, 32'd0);
      rst = 1'b0;
      run_op("after_abort", m_on, v_123, 32'h60000, 32'h60000, 32'h60000, 1'b0);

      // start held high: second operation accepted 11 edges after the first.
      @(negedge clk);
      load(m_t2, v_123);
      start = 1'b1;
      k = edge_cnt + 1;
      exp_q.push_back('{y1: 32'h20000, y2: 32'h10000, y3: 32'h60000, sat: 1'b0, k: k});
      exp_q.push_back('{y1: 32'h20000, y2: 32'h10000, y3: 32'h60000, sat: 1'b0, k: k + 11});
      while (edge_cnt < k + 11) @(negedge clk);
      start = 1'b0;
      wait_done("back_to_back");
      repeat (5) @(negedge clk);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
